// File: rtl/fptd_section_if.sv
// -----------------------------------------------------------------------------
// fptd_section_if
//
// Bundles the per-section control, data and result signals of one FPTD
// trellis section. Clock and reset are not part of the bundle.
//
// Parameters: N (channel LLR width), M (a-priori/metric/extrinsic width),
//             W (error counter width).
//
// Signals:
//   nClear     ctrl  synchronous clear, active when 1, wins over Enable
//   Enable     ctrl  update the section on this edge
//   ba1        in    a-priori LLR (signed, M bits)
//   ba2, ba3   in    systematic / parity channel LLRs (signed, N bits)
//   b1_ideal   in    transmitted bit for error counting
//   alpha_in   in    forward metrics of states 1..7, state k at [(k-1)*M +: M]
//   beta_in    in    backward metrics of states 1..7, same packing
//   alpha_out  out   registered normalised forward metrics, same packing
//   beta_out   out   registered normalised backward metrics, same packing
//   be1        out   registered extrinsic LLR (signed, M bits)
//   b1_hat     out   registered hard decision
//   b1_error   out   registered b1_hat != b1_ideal
//   converged  out   hard decision stable for CONV_LEN enabled cycles
//   err_count  out   saturating error count
//
// Modports: master drives the inputs (decoder array / bench), slave is the
// section itself.
// -----------------------------------------------------------------------------
interface fptd_section_if #(
  parameter int N = 4,
  parameter int M = 5,
  parameter int W = 8
);
  logic                  nClear;
  logic                  Enable;
  logic signed [M-1:0]   ba1;
  logic signed [N-1:0]   ba2;
  logic signed [N-1:0]   ba3;
  logic                  b1_ideal;
  logic [7*M-1:0]        alpha_in;
  logic [7*M-1:0]        beta_in;
  logic [7*M-1:0]        alpha_out;
  logic [7*M-1:0]        beta_out;
  logic signed [M-1:0]   be1;
  logic                  b1_hat;
  logic                  b1_error;
  logic                  converged;
  logic [W-1:0]          err_count;

  modport master (
    output nClear, Enable, ba1, ba2, ba3, b1_ideal, alpha_in, beta_in,
    input  alpha_out, beta_out, be1, b1_hat, b1_error, converged, err_count
  );

  modport slave (
    input  nClear, Enable, ba1, ba2, ba3, b1_ideal, alpha_in, beta_in,
    output alpha_out, beta_out, be1, b1_hat, b1_error, converged, err_count
  );
endinterface

// File: rtl/fptd_section_param.sv
// -----------------------------------------------------------------------------
// fptd_section_param
//
// One max-log-MAP trellis section of a fully-parallel turbo decoder for the
// LTE 8-state RSC code. Each enabled edge registers the normalised forward
// and backward state metrics, the extrinsic LLR and the hard decision, and
// updates a hard-decision stability counter (drives converged) and an
// optional saturating bit-error counter.
//
// Ports:
//   Clock   in   system clock, rising edge
//   nReset  in   asynchronous active-low reset
//   bus     slave modport of fptd_section_if (see that file for the signals)
//
// Trellis: state s = 4*r0 + 2*r1 + r2. For input bit b:
//   a = b^r1^r2, parity c = a^r0^r2, next state = (a, r0, r1).
// State 0 metrics are implicitly 0 on the inputs and are not output.
//
// Build option: define SECTION_ERRCNT_EN to implement b1_error/err_count;
// otherwise both are tied to 0 and b1_ideal is ignored.
// -----------------------------------------------------------------------------
module fptd_section_param #(
  parameter int N        = 4,
  parameter int M        = 5,
  parameter int CONV_LEN = 4,
  parameter int W        = 8
) (
  input  logic           Clock,
  input  logic           nReset,
  fptd_section_if.slave  bus
);

  // Internal arithmetic width: wide enough that no sum or difference of
  // metrics and LLRs can wrap before saturation.
  localparam int G  = M + 3;
  localparam int SW = $clog2(CONV_LEN + 1);

  localparam logic signed [G-1:0] NEG_INF = {1'b1, {(G-1){1'b0}}};
  localparam logic signed [G-1:0] SAT_HI  = G'((2 ** (M - 1)) - 1);
  localparam logic signed [G-1:0] SAT_LO  = G'(-(2 ** (M - 1)));
  localparam logic [SW-1:0]       STAB_MAX = SW'(CONV_LEN);

  function automatic logic signed [M-1:0] sat_m(input logic signed [G-1:0] x);
    if (x > SAT_HI)      return SAT_HI[M-1:0];
    else if (x < SAT_LO) return SAT_LO[M-1:0];
    else                 return x[M-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Operand extension
  // ---------------------------------------------------------------------------
  logic signed [N-1:0]   ba2_l, ba3_l;
  logic signed [G-1:0]   ba1_x, ba2_x, ba3_x, ba12_x;
  logic signed [G-1:0]   alpha_x [8];
  logic signed [G-1:0]   beta_x  [8];

  assign ba2_l  = bus.ba2;
  assign ba3_l  = bus.ba3;
  assign ba1_x  = G'(bus.ba1);
  assign ba2_x  = G'(ba2_l);
  assign ba3_x  = G'(ba3_l);
  assign ba12_x = ba1_x + ba2_x;

  always_comb begin
    alpha_x[0] = '0;
    beta_x[0]  = '0;
    for (int k = 1; k < 8; k++) begin
      alpha_x[k] = G'($signed(bus.alpha_in[(k-1)*M +: M]));
      beta_x[k]  = G'($signed(bus.beta_in[(k-1)*M +: M]));
    end
  end

  // ---------------------------------------------------------------------------
  // Add-compare-select over all 16 transitions
  // ---------------------------------------------------------------------------
  logic signed [G-1:0] alpha_max [8];
  logic signed [G-1:0] beta_max  [8];
  logic signed [G-1:0] ext_max1, ext_max0;

  // NOTE: every variable written here gets a default before the loops, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    logic [2:0]          st;
    logic [2:0]          ns;
    logic                a_bit, c_bit;
    logic signed [G-1:0] par, gam, av, bv, ev;
    st = '0; ns = '0; a_bit = 1'b0; c_bit = 1'b0;
    par = '0; gam = '0; av = '0; bv = '0; ev = '0;
    ext_max1 = NEG_INF;
    ext_max0 = NEG_INF;
    for (int s = 0; s < 8; s++) begin
      alpha_max[s] = NEG_INF;
      beta_max[s]  = NEG_INF;
    end
    for (int sp = 0; sp < 8; sp++) begin
      for (int bi = 0; bi < 2; bi++) begin
        st    = 3'(sp);
        a_bit = 1'(bi) ^ st[1] ^ st[0];
        c_bit = a_bit ^ st[2] ^ st[0];
        ns    = {a_bit, st[2], st[1]};
        par   = c_bit ? ba3_x : '0;
        gam   = (bi == 1) ? ba12_x + par : par;
        av    = alpha_x[sp] + gam;
        bv    = beta_x[ns] + gam;
        // Extrinsic excludes the systematic and a-priori terms.
        ev    = alpha_x[sp] + par + beta_x[ns];
        if (av > alpha_max[ns]) alpha_max[ns] = av;
        if (bv > beta_max[sp])  beta_max[sp]  = bv;
        if (bi == 1) begin
          if (ev > ext_max1) ext_max1 = ev;
        end else begin
          if (ev > ext_max0) ext_max0 = ev;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Normalisation, extrinsic and hard decision
  // ---------------------------------------------------------------------------
  logic [7*M-1:0]      alpha_new, beta_new;
  logic signed [M-1:0] be_new;
  logic signed [G-1:0] hd_sum;
  logic                hat_new;

  always_comb begin
    alpha_new = '0;
    beta_new  = '0;
    for (int k = 1; k < 8; k++) begin
      alpha_new[(k-1)*M +: M] = sat_m(alpha_max[k] - alpha_max[0]);
      beta_new[(k-1)*M +: M]  = sat_m(beta_max[k] - beta_max[0]);
    end
  end

  assign be_new  = sat_m(ext_max1 - ext_max0);
  assign hd_sum  = G'(be_new) + ba1_x + ba2_x;
  // Strictly positive decides 1; zero decides 0.
  assign hat_new = !hd_sum[G-1] && (hd_sum != '0);

  // ---------------------------------------------------------------------------
  // Registered results and stability counter
  // ---------------------------------------------------------------------------
  logic [7*M-1:0]      alpha_q, beta_q;
  logic signed [M-1:0] be_q;
  logic                hat_q;
  logic [SW-1:0]       stab_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, including hat_q in the stability compare.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      alpha_q <= '0;
      beta_q  <= '0;
      be_q    <= '0;
      hat_q   <= 1'b0;
      stab_q  <= '0;
    end else if (bus.nClear) begin
      alpha_q <= '0;
      beta_q  <= '0;
      be_q    <= '0;
      hat_q   <= 1'b0;
      stab_q  <= '0;
    end else if (bus.Enable) begin
      alpha_q <= alpha_new;
      beta_q  <= beta_new;
      be_q    <= be_new;
      hat_q   <= hat_new;
      if (hat_new == hat_q) begin
        if (stab_q != STAB_MAX) stab_q <= stab_q + SW'(1);
      end else begin
        stab_q <= '0;
      end
    end
  end

  assign bus.alpha_out = alpha_q;
  assign bus.beta_out  = beta_q;
  assign bus.be1       = be_q;
  assign bus.b1_hat    = hat_q;
  assign bus.converged = (stab_q >= STAB_MAX);

  // ---------------------------------------------------------------------------
  // Optional bit-error counter
  // ---------------------------------------------------------------------------
`ifdef SECTION_ERRCNT_EN
  logic          err_new;
  logic          err_q;
  logic [W-1:0]  cnt_q;

  assign err_new = hat_new ^ bus.b1_ideal;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (bus.nClear) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (bus.Enable) begin
      err_q <= err_new;
      if (err_new && (cnt_q != {W{1'b1}})) cnt_q <= cnt_q + W'(1);
    end
  end

  assign bus.b1_error  = err_q;
  assign bus.err_count = cnt_q;
`else
  logic unused_ideal;
  assign unused_ideal  = bus.b1_ideal;
  assign bus.b1_error  = 1'b0;
  assign bus.err_count = W'(0);
`endif

endmodule

// File: tb/tb_fptd_section_param.sv
// -----------------------------------------------------------------------------
// tb_fptd_section_param
//
// Self-checking bench for fptd_section_param (N=4, M=5, CONV_LEN=4, W=3).
// A table of vectors (hand-computed and model-computed expectations) is
// applied one per cycle; the expected register image is pushed to a
// scoreboard queue when the vector is driven and popped after the edge.
// Hand sequences cover convergence, error saturation, clear and async reset.
// Error-counter expectations follow SECTION_ERRCNT_EN.
// -----------------------------------------------------------------------------
module tb_fptd_section_param;

  localparam int N    = 4;
  localparam int M    = 5;
  localparam int CONV = 4;
  localparam int W    = 3;
  localparam int MAXV = 2 ** (M - 1) - 1;
  localparam int MINV = -(2 ** (M - 1));
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  typedef struct {
    string               name;
    logic                en;
    logic signed [M-1:0] ba1;
    logic signed [N-1:0] ba2;
    logic signed [N-1:0] ba3;
    logic                ideal;
    logic [7*M-1:0]      ain;
    logic [7*M-1:0]      bin;
    logic [7*M-1:0]      exp_a;
    logic [7*M-1:0]      exp_b;
    logic signed [M-1:0] exp_be;
    logic                exp_hat;
  } vec_t;

  typedef struct {
    logic [7*M-1:0]      a;
    logic [7*M-1:0]      b;
    logic signed [M-1:0] be;
    logic                hat;
    logic                err;
    logic                conv;
    logic [W-1:0]        cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vec_t tbl[$];
  exp_t sbq[$];
  exp_t cur;
  int   stab_m;

  fptd_section_if #(.N(N), .M(M), .W(W)) sif();

  fptd_section_param #(.N(N), .M(M), .CONV_LEN(CONV), .W(W)) dut (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic logic [7*M-1:0] pk7(input int s1, s2, s3, s4, s5, s6, s7);
    logic [7*M-1:0] r;
    r = {M'(s7), M'(s6), M'(s5), M'(s4), M'(s3), M'(s2), M'(s1)};
    return r;
  endfunction

  // Reference model: alpha by predecessor pairs, beta/extrinsic by branches.
  function automatic vec_t fill(input vec_t v);
    int   am[8], bm[8], an[8], bn[8];
    int   a, c, p, ns, t, e, best1, best0, be, g1, g3;
    vec_t o;
    o = v;
    g1 = int'(v.ba1) + int'(v.ba2);
    g3 = int'(v.ba3);
    am[0] = 0;
    bm[0] = 0;
    for (int k = 1; k < 8; k++) begin
      am[k] = int'($signed(v.ain[(k-1)*M +: M]));
      bm[k] = int'($signed(v.bin[(k-1)*M +: M]));
    end
    for (int s = 0; s < 8; s++) begin
      an[s] = -100000;
      a = s >> 2;
      for (int r2 = 0; r2 < 2; r2++) begin
        p = ((s & 3) << 1) | r2;
        c = a ^ ((s >> 1) & 1) ^ r2;
        t = am[p] + (a ^ (s & 1) ^ r2) * g1 + c * g3;
        if (t > an[s]) an[s] = t;
      end
    end
    best1 = -100000;
    best0 = -100000;
    for (int sp = 0; sp < 8; sp++) begin
      bn[sp] = -100000;
      for (int b = 0; b < 2; b++) begin
        a  = b ^ ((sp >> 1) & 1) ^ (sp & 1);
        c  = a ^ (sp >> 2) ^ (sp & 1);
        ns = 4 * a + 2 * (sp >> 2) + ((sp >> 1) & 1);
        t  = bm[ns] + b * g1 + c * g3;
        if (t > bn[sp]) bn[sp] = t;
        e  = am[sp] + c * g3 + bm[ns];
        if (b == 1) begin
          if (e > best1) best1 = e;
        end else begin
          if (e > best0) best0 = e;
        end
      end
    end
    for (int k = 1; k < 8; k++) begin
      o.exp_a[(k-1)*M +: M] = M'(clamp(an[k] - an[0]));
      o.exp_b[(k-1)*M +: M] = M'(clamp(bn[k] - bn[0]));
    end
    be        = clamp(best1 - best0);
    o.exp_be  = M'(be);
    o.exp_hat = (be + g1) > 0;
    return o;
  endfunction

  function automatic vec_t mk(input string name, input logic en, input int ba1, ba2, ba3,
                              input logic ideal, input logic [7*M-1:0] ain, bin);
    vec_t v;
    v.name = name; v.en = en; v.ideal = ideal;
    v.ba1 = M'(ba1); v.ba2 = N'(ba2); v.ba3 = N'(ba3);
    v.ain = ain; v.bin = bin;
    v.exp_a = '0; v.exp_b = '0; v.exp_be = '0; v.exp_hat = 1'b0;
    return fill(v);
  endfunction

  function automatic vec_t mk_hand(input string name, input int ba1, ba2, ba3, input logic ideal,
                                   input logic [7*M-1:0] ain, bin, ea, eb,
                                   input int ebe, input logic ehat);
    vec_t v;
    v = mk(name, 1'b1, ba1, ba2, ba3, ideal, ain, bin);
    v.exp_a = ea; v.exp_b = eb; v.exp_be = M'(ebe); v.exp_hat = ehat;
    return v;
  endfunction

  function automatic vec_t mk_rand(input string name, input logic en);
    logic [63:0] ra, rb;
    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    return mk(name, en, int'($signed(5'($urandom_range(0, 31)))),
              int'($signed(4'($urandom_range(0, 15)))),
              int'($signed(4'($urandom_range(0, 15)))),
              1'($urandom_range(0, 1)), ra[7*M-1:0], rb[7*M-1:0]);
  endfunction

  task automatic reset_model();
    cur.a = '0; cur.b = '0; cur.be = '0; cur.hat = 1'b0;
    cur.err = 1'b0; cur.conv = 1'b0; cur.cnt = '0;
    stab_m = 0;
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, ".alpha_out"}, 64'(sif.alpha_out), 64'(e.a));
    check({tag, ".beta_out"},  64'(sif.beta_out),  64'(e.b));
    check({tag, ".be1"},       64'(sif.be1),       64'(e.be));
    check({tag, ".b1_hat"},    64'(sif.b1_hat),    64'(e.hat));
    check({tag, ".b1_error"},  64'(sif.b1_error),  64'(e.err));
    check({tag, ".converged"}, 64'(sif.converged), 64'(e.conv));
    check({tag, ".err_count"}, 64'(sif.err_count), 64'(e.cnt));
  endtask

  task automatic compare_zero(input string tag);
    exp_t z;
    z.a = '0; z.b = '0; z.be = '0; z.hat = 1'b0; z.err = 1'b0; z.conv = 1'b0; z.cnt = '0;
    compare_all(tag, z);
  endtask

  // Drive one vector at the falling edge, predict, compare after the rise.
  task automatic step(input vec_t v, input logic clr);
    exp_t e;
    @(negedge clk);
    sif.nClear   = clr;
    sif.Enable   = v.en;
    sif.ba1      = v.ba1;
    sif.ba2      = v.ba2;
    sif.ba3      = v.ba3;
    sif.b1_ideal = v.ideal;
    sif.alpha_in = v.ain;
    sif.beta_in  = v.bin;
    if (clr) begin
      reset_model();
    end else if (v.en) begin
      if (v.exp_hat == cur.hat) stab_m = (stab_m < CONV) ? stab_m + 1 : CONV;
      else                      stab_m = 0;
      cur.a   = v.exp_a;
      cur.b   = v.exp_b;
      cur.be  = v.exp_be;
      cur.hat = v.exp_hat;
`ifdef SECTION_ERRCNT_EN
      cur.err = v.exp_hat ^ v.ideal;
      if (cur.err && cur.cnt != CNT_MAX) cur.cnt = cur.cnt + W'(1);
`endif
    end
    cur.conv = (stab_m >= CONV);
    sbq.push_back(cur);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    compare_all(v.name, e);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    vec_t v_zero, v_b3, v_b3b, v_err, v_hand;
    logic [W-1:0] sat_exp;
    checks = 0;
    errors = 0;
    reset_model();

    // Table: hand-computed entries first, then model-computed random ones.
    tbl.push_back(mk_hand("zero", 0, 0, 0, 1'b1, '0, '0, '0, '0, 0, 1'b0));
    tbl.push_back(mk_hand("ba2_pos", 0, 5, 0, 1'b0, '0, '0, '0, '0, 0, 1'b1));
    tbl.push_back(mk_rand("hold_a", 1'b0));
    tbl.push_back(mk_hand("ba3_hand", 0, 7, 6, 1'b1, '0, pk7(5, 0, 0, 0, 0, 0, 0),
                          pk7(-6, -6, 0, 0, -6, -6, 0), pk7(0, -1, -2, -6, -6, 0, 0),
                          -5, 1'b1));
    tbl.push_back(mk_hand("sat_pos", 15, 7, 0, 1'b0, pk7(-16, 15, 15, 15, 15, 15, 15), '0,
                          pk7(15, 15, 15, 15, 15, 15, 15), '0, 0, 1'b1));
    tbl.push_back(mk_hand("sat_neg", 0, 0, 0, 1'b0, pk7(15, -16, -16, -16, -16, -16, -16), '0,
                          pk7(-16, -16, -16, 0, -16, -16, -16), '0, 0, 1'b0));
    tbl.push_back(mk_rand("hold_b", 1'b0));
    for (int i = 0; i < 15; i++)
      tbl.push_back(mk_rand($sformatf("rnd%0d", i), (i % 3) != 2));

    v_zero = mk("clear", 1'b1, 0, 0, 0, 1'b0, '0, '0);
    v_b3   = mk("ba3_7", 1'b1, 0, 0, 7, 1'b0, '0, '0);
    v_b3b  = mk("ba3_7_ba2_5", 1'b1, 0, 5, 7, 1'b0, '0, '0);
    v_err  = mk("err_run", 1'b1, 0, 0, 0, 1'b1, '0, '0);
    v_hand = tbl[3];

    // Reset
    rst_n        = 1'b0;
    sif.nClear   = 1'b0;
    sif.Enable   = 1'b0;
    sif.ba1      = '0;
    sif.ba2      = '0;
    sif.ba3      = '0;
    sif.b1_ideal = 1'b0;
    sif.alpha_in = '0;
    sif.beta_in  = '0;
    #13;
    compare_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], 1'b0);

    // Convergence after CONV_LEN stable decisions, drop on a change.
    step(v_zero, 1'b1);
    for (int i = 1; i <= CONV; i++) begin
      step(v_b3, 1'b0);
      check($sformatf("conv_edge%0d", i), 64'(sif.converged), 64'(i == CONV));
    end
    step(v_b3b, 1'b0);
    check("conv_drop", 64'(sif.converged), 64'(0));
    check("conv_drop_hat", 64'(sif.b1_hat), 64'(1));

    // Error counter saturation, then clear with Enable high.
    step(v_zero, 1'b1);
    for (int i = 0; i < 10; i++) step(v_err, 1'b0);
`ifdef SECTION_ERRCNT_EN
    sat_exp = CNT_MAX;
    check("err_sat_flag", 64'(sif.b1_error), 64'(1));
`else
    sat_exp = '0;
    check("err_off_flag", 64'(sif.b1_error), 64'(0));
`endif
    check("err_sat_count", 64'(sif.err_count), 64'(sat_exp));
    step(v_err, 1'b1);
    compare_zero("clear_en");

    // Asynchronous reset in the middle of a cycle.
    step(v_hand, 1'b0);
    step(v_err, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    compare_zero("async_reset");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(v_b3, 1'b0);
    step(v_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
